// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
// The optional SERIAL_ADD_OVF_EN macro is consumed by serial_add_ctrl.sv.
package serial_add_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// Single 1-bit full adder; the serial datapath reuses this one cell every bit-time.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: {cout,sum} = a + b + cin, LSB first, one bit per clock.
// Define SERIAL_ADD_OVF_EN to enable the signed-overflow flag; otherwise ovf is tied to 0.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, b_reg, sum_reg;
    logic [CW-1:0]    cnt_reg;
    logic             carry_reg, cout_reg;
    logic             fa_s, fa_co;
    logic             last_bit;

    fa_cell u_fa (
        .a  (a_reg[0]),
        .b  (b_reg[0]),
        .ci (carry_reg),
        .s  (fa_s),
        .co (fa_co)
    );

    assign last_bit = (cnt_reg == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Sum bits enter at the MSB and shift right, so after WIDTH steps the word is aligned.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            cnt_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        carry_reg <= cin;
                        cnt_reg   <= '0;
                    end
                end
                RUN: begin
                    a_reg     <= a_reg >> 1;
                    b_reg     <= b_reg >> 1;
                    sum_reg   <= {fa_s, sum_reg[WIDTH-1:1]};
                    carry_reg <= fa_co;
                    cnt_reg   <= cnt_reg + CW'(1);
                    if (last_bit) cout_reg <= fa_co;
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    logic ovf_reg;

    // On the MSB step carry_reg is the carry into the MSB and fa_co the carry out of it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ovf_reg <= 1'b0;
        end else if (state_reg == RUN && last_bit) begin
            ovf_reg <= carry_reg ^ fa_co;
        end
    end

    assign ovf = ovf_reg;
`else
    assign ovf = 1'b0;
`endif

    assign busy = (state_reg != IDLE);
    assign done = (state_reg == DONE);
    assign sum  = sum_reg;
    assign cout = cout_reg;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed table, multi-cycle corner cases, random runs.
module tb_serial_add_ctrl;

`ifdef SERIAL_ADD_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       resetn = 1'b0;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       cin4 = 1'b0;
    logic       busy4, done4, cout4, ovf4;
    logic [3:0] sum4;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       cin8 = 1'b0;
    logic       busy8, done8, cout8, ovf8;
    logic [7:0] sum8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .resetn(resetn), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
    );

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .resetn(resetn), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] sum;
        logic       cout;
        logic       ovf;   // expected value when the overflow feature is built in
    } vec_t;

    vec_t tbl[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge with dut4 idle; returns at the first idle negedge afterwards.
    task automatic run4(input logic [3:0] va, input logic [3:0] vb, input logic vc,
                        input logic [3:0] es, input logic ec, input logic eo);
        start4 = 1'b1; a4 = va; b4 = vb; cin4 = vc;
        @(posedge clk);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start4 = 1'b0; a4 = ~va; b4 = ~vb; cin4 = ~vc;
            end
            check("busy4_run", 32'(busy4), 32'd1);
            check("done4_timing", 32'(done4), 32'(k == 5));
            if (k == 5) begin
                check("sum4", 32'(sum4), 32'(es));
                check("cout4", 32'(cout4), 32'(ec));
                check("ovf4", 32'(ovf4), 32'(eo & OVF_EN));
            end
        end
        @(negedge clk);
        check("busy4_idle", 32'(busy4), 32'd0);
        check("done4_idle", 32'(done4), 32'd0);
        $display("w4 a=%h b=%h cin=%0d -> sum=%h cout=%0d ovf=%0d", va, vb, vc, sum4, cout4, ovf4);
    endtask

    task automatic run8(input logic [7:0] va, input logic [7:0] vb, input logic vc);
        logic [8:0] ref9;
        logic       eo;
        int         got;
        ref9 = {1'b0, va} + {1'b0, vb} + {8'd0, vc};
        eo   = (va[7] == vb[7]) && (ref9[7] != va[7]);
        got  = 0;
        start8 = 1'b1; a8 = va; b8 = vb; cin8 = vc;
        @(posedge clk);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start8 = 1'b0; a8 = ~va; b8 = ~vb; cin8 = ~vc;
            end
            if (done8) begin
                got = k;
                break;
            end
        end
        check("done8_latency", 32'(got), 32'd9);
        check("sum8", 32'(sum8), 32'(ref9[7:0]));
        check("cout8", 32'(cout8), 32'(ref9[8]));
        check("ovf8", 32'(ovf8), 32'(eo & OVF_EN));
        @(negedge clk);
        check("busy8_idle", 32'(busy8), 32'd0);
        $display("w8 a=%h b=%h cin=%0d -> sum=%h cout=%0d", va, vb, vc, sum8, cout8);
    endtask

    initial begin
        int dones;
        logic [3:0] ra, rb;
        logic       rc;
        logic [4:0] r5;

        //            a      b     cin   sum   cout  ovf
        tbl[0] = '{4'h7, 4'h8, 1'b0, 4'hF, 1'b0, 1'b0};
        tbl[1] = '{4'hF, 4'h0, 1'b1, 4'h0, 1'b1, 1'b0};
        tbl[2] = '{4'h3, 4'h3, 1'b0, 4'h6, 1'b0, 1'b0};
        tbl[3] = '{4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1};
        tbl[4] = '{4'h8, 4'h8, 1'b0, 4'h0, 1'b1, 1'b1};
        tbl[5] = '{4'h5, 4'hA, 1'b0, 4'hF, 1'b0, 1'b0};
        tbl[6] = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0};
        tbl[7] = '{4'h9, 4'h6, 1'b1, 4'h0, 1'b1, 1'b0};
        tbl[8] = '{4'h4, 4'h4, 1'b0, 4'h8, 1'b0, 1'b1};

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy4), 32'd0);
        check("rst_done", 32'(done4), 32'd0);
        check("rst_sum", 32'(sum4), 32'd0);
        check("rst_cout", 32'(cout4), 32'd0);
        check("rst_ovf", 32'(ovf4), 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        // Back-to-back table: each op starts in the idle cycle right after the previous DONE.
        for (int i = 0; i < 9; i++) begin
            run4(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sum, tbl[i].cout, tbl[i].ovf);
        end

        // Start during RUN and during DONE must both be ignored.
        dones = 0;
        start4 = 1'b1; a4 = 4'h1; b4 = 4'h1; cin4 = 1'b0;
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (done4) dones++;
            if (k == 5) begin
                check("ign_sum", 32'(sum4), 32'h2);
                check("ign_cout", 32'(cout4), 32'd0);
            end
            if (k == 6 || k == 7) check("ign_busy_after_done", 32'(busy4), 32'd0);
            case (k)
                2, 5:    begin start4 = 1'b1; a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1; end
                default: start4 = 1'b0;
            endcase
        end
        check("ign_single_done", 32'(dones), 32'd1);
        $display("w4 ignored-start sequence -> sum=%h cout=%0d dones=%0d", sum4, cout4, dones);

        // Reset in the second RUN cycle aborts without a done.
        run4(4'h7, 4'h8, 1'b0, 4'hF, 1'b0, 1'b0);
        start4 = 1'b1; a4 = 4'h1; b4 = 4'h2; cin4 = 1'b0;
        @(posedge clk);
        @(negedge clk); start4 = 1'b0;
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        check("abort_busy", 32'(busy4), 32'd0);
        check("abort_done", 32'(done4), 32'd0);
        check("abort_sum", 32'(sum4), 32'd0);
        check("abort_cout", 32'(cout4), 32'd0);
        dones = 0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done4) dones++;
        end
        check("abort_no_done", 32'(dones), 32'd0);
        $display("w4 reset abort -> busy=%0d sum=%h dones=%0d", busy4, sum4, dones);
        run4(4'h5, 4'hA, 1'b0, 4'hF, 1'b0, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            ra = 4'($urandom_range(15));
            rb = 4'($urandom_range(15));
            rc = 1'($urandom_range(1));
            r5 = {1'b0, ra} + {1'b0, rb} + {4'd0, rc};
            run4(ra, rb, rc, r5[3:0], r5[4], (ra[3] == rb[3]) && (r5[3] != ra[3]));
        end

        for (int i = 0; i < 1000; i++) begin
            run8(8'($urandom_range(255)), 8'($urandom_range(255)), 1'($urandom_range(1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout reached before completion");
        $fatal(1, "timeout");
    end

endmodule
